timer_sched: RTL and testbench
==============================

Name: timer_sched

Overview:
- Round-robin scheduler that shares one down-counting timeout timer among N_REQ requesters.
- A requester raises req with a load value. The scheduler grants the timer, counts the value down and pulses done back to the granted requester.
- out is a single-cycle expiry strobe, matching the existing timer's out semantics.
- Sits between the protocol FSMs that need timeouts and the single shared counter resource.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 8, width of each load value and of the shared counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  level request per requester; held until done or abort
load_val  input  N_REQ*CNT_W  per-requester timeout value; slice i = bits [i*CNT_W +: CNT_W]
grant  output  N_REQ  one-hot, registered; owner of the timer
done  output  N_REQ  one-cycle pulse to the owner on expiry
busy  output  1  high whenever state != IDLE
out  output  1  one-cycle pulse on any expiry (OR of done)
count  output  CNT_W  current counter value, for debug

Behaviour:
- Reset (synchronous, checked first, overrides everything):
  - state=IDLE; grant=0, done=0, out=0, busy=0, count=0.
  - Round-robin pointer rr_last = N_REQ-1, so requester 0 has first priority.
- IDLE:
  - If req!=0 at edge k, pick the first set bit searching from rr_last+1 upward with wrap-around.
  - At edge k: grant[g]=1, count=load_val[g], rr_last=g, state->COUNT.
  - If req==0, stay in IDLE.
- COUNT:
  - Each edge with req[g]=1 and count!=0: count=count-1.
  - Edge with req[g]=1 and count==0: state->DONE, done[g]=1, out=1.
  - Timing: done is visible L+1 cycles after grant, where L is the load value. L=0 gives done 1 cycle after grant.
  - Abort: edge with req[g]=0 (any count) -> state IDLE, grant=0, count=0, no done/out. rr_last still = g.
- DONE:
  - Lasts exactly one cycle. grant[g] is still high. done[g]=1, out=1.
  - Next edge: grant=0, done=0, out=0, state->IDLE, regardless of req.
- Gaps between grants:
  - At least one IDLE cycle separates consecutive grants. IDLE is where arbitration happens.
  - A requester still holding req after done is re-eligible, but only after all higher-rotation requesters.
- Inputs outside IDLE:
  - load_val is sampled only on the grant edge. Later changes are ignored.
  - req of non-owners is ignored outside IDLE, with no queueing beyond the level req.
- Arithmetic:
  - Counter is unsigned CNT_W bits with no wrap. Decrement never occurs at 0.
- Invariants:
  - grant is one-hot or zero at all times. done is a subset of grant. out == |done.
- Simultaneous events:
  - Reset in the same cycle as expiry: reset wins, no done pulse.
  - req drop in the same edge as count==0 in COUNT: abort wins, no done.
- Reset mid-COUNT: returns to IDLE next edge and rr_last returns to N_REQ-1.

Test Plan:
- Reset for 2 cycles with req=4'b0000 -> grant=0, done=0, out=0, busy=0, count=0; stays in IDLE.
- Single request: req=4'b0001, load_val[0]=3 -> grant=0001 one edge later; count 3,2,1,0; done=0001 and out=1 for exactly one cycle, 4 cycles after grant; then grant=0 and busy=0.
- Round-robin fairness: req=4'b1111, all loads=1, held continuously -> grant order 0,1,2,3,0. Each done pulses once per tenure, with one IDLE cycle between tenures.
- Zero load: req=4'b0100, load_val[2]=0 -> done[2] pulses 1 cycle after grant; out matches.
- Abort: req[1] granted with load 10, req[1] dropped after 3 cycles -> grant=0 next edge, no done/out. Then req=4'b0011 -> requester 0 granted, since rr_last=1 wraps to 2, 3, then 0.
- Reset mid-operation: reset asserted when count=5 -> next edge state IDLE, all outputs 0, no done. Then req=4'b1000 and req[0] set together -> requester 0 granted first.

Source files
------------

// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler sharing one down-counting timeout timer among N_REQ requesters
module timer_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] load_val,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   out,
    output logic [CNT_W-1:0]       count
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

    state_e           state_q;
    logic [IW-1:0]    rr_last_q;
    logic [IW-1:0]    pick_d;
    logic [IW-1:0]    cand;
    logic             found;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] done_q;
    logic [CNT_W-1:0] count_q;

    // pick the first requester after the previous owner, wrapping around
    always_comb begin
        pick_d = rr_last_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(rr_last_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                pick_d = cand;
                found  = 1'b1;
            end
        end
    end

    // arbitration in IDLE, countdown in COUNT, one-cycle expiry in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            count_q   <= '0;
            rr_last_q <= IW'(N_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q   <= COUNT;
                        grant_q   <= N_REQ'(1) << pick_d;
                        count_q   <= load_val[int'(pick_d)*CNT_W +: CNT_W];
                        rr_last_q <= pick_d;
                    end
                end
                COUNT: begin
                    if (!req[rr_last_q]) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        count_q <= '0;
                    end else if (count_q == '0) begin
                        state_q <= DONE;
                        done_q  <= grant_q;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    done_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    done_q  <= '0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign count = count_q;
    assign busy  = state_q != IDLE;
    assign out   = |done_q;
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed and random stimulus against an elapsed-time reference model
module tb_timer_sched;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N*W-1:0] load_val;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
    logic         out;
    logic [W-1:0] count;

    int total = 0;
    int bad = 0;

    // reference: an active tenure is (owner, load, cycles elapsed since the grant edge)
    bit m_act;
    int m_g, m_l, m_t, m_rr;

    timer_sched #(.N_REQ(N), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .load_val(load_val),
        .grant(grant), .done(done), .busy(busy), .out(out), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input int rr, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic setl(input int i, input int v);
        load_val[i*W +: W] = W'(v);
    endtask

    task automatic step();
        logic [N-1:0] eg, ed;
        int ec;
        @(posedge clk);
        if (reset) begin
            m_act = 0;
            m_rr = N - 1;
        end else if (m_act) begin
            if (m_t <= m_l) begin
                if (!req[m_g]) m_act = 0;
                else m_t++;
            end else begin
                m_act = 0;
            end
        end else if (req != '0) begin
            m_g = first_from(m_rr, req);
            m_rr = m_g;
            m_l = int'(load_val[m_g*W +: W]);
            m_t = 0;
            m_act = 1;
        end
        #1;
        eg = m_act ? N'(1) << m_g : '0;
        ed = (m_act && m_t == m_l + 1) ? eg : '0;
        ec = (m_act && m_t <= m_l) ? m_l - m_t : 0;
        check("grant", 32'(grant), 32'(eg));
        check("done", 32'(done), 32'(ed));
        check("count", 32'(count), 32'(ec));
        check("busy", 32'(busy), 32'(m_act));
        check("out", 32'(out), 32'(ed != '0));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_act = 0; m_g = 0; m_l = 0; m_t = 0; m_rr = N - 1;
        reset = 1'b1;
        req = '0;
        load_val = '0;
        steps(2);
        reset = 1'b0;
        steps(2);
        // single request, load 3: done four cycles after grant
        req = 4'b0001; setl(0, 3);
        steps(5);
        req = '0;
        steps(2);
        // round-robin fairness with all loads 1
        req = 4'b1111;
        for (int i = 0; i < N; i++) setl(i, 1);
        steps(20);
        req = '0;
        steps(3);
        // zero load
        req = 4'b0100; setl(2, 0);
        steps(2);
        req = '0;
        steps(2);
        // abort, then rotation continues past the aborted owner
        req = 4'b0010; setl(1, 10);
        steps(4);
        req = '0;
        steps(1);
        req = 4'b0011; setl(0, 2); setl(1, 2);
        steps(5);
        req = '0;
        steps(3);
        // reset mid-count restores requester 0 priority
        req = 4'b0001; setl(0, 8); setl(3, 4);
        for (int i = 0; i < 12; i++) begin
            step();
            if (m_act && m_l - m_t == 5) break;
        end
        check("count_reached_5", 32'(count), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1001;
        step();
        check("grant_after_reset", 32'(grant), 32'b0001);
        steps(9);
        req = '0;
        steps(3);
        // random traffic: sticky requests, changing loads, occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) setl(i, int'($urandom_range(0, 6)));
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        req = '0;
        steps(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
